uart_hex_framer: RTL and testbench
==================================

# uart_hex_framer

Streaming formatter between the UART control FSM and the UART transmitter. It turns each raw sensor byte into two uppercase ASCII hex characters. Bytes within a line are separated by a configurable separator, and every line is terminated after a configurable number of bytes. It converts binary I2C sensor readings into terminal-readable text without changing the byte-level valid/ready contract on either side.

## Interface
- DATA_DEPTH, 8: byte width; fixed at 8, other values unsupported.
- BYTES_PER_LINE, 2: bytes emitted per line before the terminator; legal range 1..255.
- SEP_CHAR, 32: ASCII code sent between bytes within a line (default space).
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_data  in  8  raw byte from the UART control FSM.
- i_valid  in  1  i_data valid.
- o_ready  out  1  framer accepts a byte this cycle.
- o_data  out  8  ASCII character to the UART transmitter.
- o_valid  out  1  o_data valid.
- i_ready  in  1  transmitter accepts o_data this cycle.
- i_flush  in  1  single-cycle request to terminate the current partial line.
- o_busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, HI, LO, SEP, CR, LF.
- A handshake occurs on the input side when i_valid & o_ready, and on the output side when o_valid & i_ready.
- IDLE:
  - o_ready = 1 unless a flush is being taken.
  - On an input handshake, capture i_data into r_byte and go to HI.
- HI:
  - o_data = ascii(r_byte[7:4]), o_valid = 1.
  - On an output handshake, go to LO.
- LO:
  - o_data = ascii(r_byte[3:0]).
  - On an output handshake, r_count increments.
  - If the new count equals BYTES_PER_LINE, clear r_count and go to the terminator state; otherwise go to SEP.
- SEP:
  - o_data = SEP_CHAR.
  - On an output handshake, go to IDLE.
- CR: o_data = 8'h0D; on an output handshake, go to LF.
- LF: o_data = 8'h0A; on an output handshake, clear r_count and go to IDLE.
- Terminator state: CR when the CR feature is compiled in, LF otherwise.
- ascii(n): n <= 9 maps to 8'h30+n; n >= 10 maps to 8'h37+n, giving 'A'..'F'.
- Flush:
  - i_flush is sampled in IDLE only and ignored in every other state.
  - In IDLE with r_count != 0, a flush forces o_ready = 0 that cycle and moves to the terminator state; flush wins over a simultaneous i_valid.
  - With r_count == 0, a flush is a no-op and does not block acceptance.
- The separator is always sent after a non-final byte. A flush therefore emits the terminator after the trailing separator.
- BYTES_PER_LINE = 1: SEP is never entered.
- o_valid = 1 in HI, LO, SEP, CR and LF; o_valid = 0 in IDLE.
- o_data holds stable while o_valid & !i_ready.

## Timing
- Reset values: state IDLE, r_count 0, r_byte 0, o_valid 0, o_data 0, o_busy 0, o_ready 1.
- Reset mid-character or mid-line: the partial output is abandoned, no terminator is sent, and the first byte after reset starts a new line.
- Outputs decode combinationally from the state register, r_byte and r_count; there is no input-to-output combinational path except i_flush → o_ready.
- Latency: a byte accepted at edge t presents its HI character from t+1.
- Throughput with i_ready held at 1:
  - a non-final byte takes 4 cycles (IDLE, HI, LO, SEP);
  - a line-final byte takes 5 cycles (CR compiled in) or 4 cycles (CR compiled out).
- Backpressure: each output state holds indefinitely until i_ready; o_ready stays 0 for that whole period.

## Configuration
- UART_HEX_FRAMER_CRLF_EN defined: the terminator is CR then LF (8'h0D, 8'h0A), and the CR state exists.
- Macro undefined: the terminator is LF only, and the CR state is removed from the encoding.

## Structure
- Shared package uart_hex_pkg.vh holds:
  - the state encodings;
  - the ASCII constants CR, LF, '0' base and 'A'-10 base.
- One sub-module, nibble_to_ascii: 4-bit in, 8-bit out, purely combinational, instantiated once and muxed on state (HI selects the upper nibble, LO the lower).
- r_count width: $clog2(BYTES_PER_LINE+1).

## Test plan
- Defaults, CRLF enabled, i_ready = 1, bytes 0x3A then 0xF0 → output stream 0x33, 0x41, 0x20, 0x46, 0x30, 0x0D, 0x0A; o_busy low afterwards.
- Same stimulus with CRLF disabled → 0x33, 0x41, 0x20, 0x46, 0x30, 0x0A.
- Byte 0x09, then i_flush pulsed in IDLE → 0x30, 0x39, 0x20, then the terminator.
- i_flush asserted with r_count == 0 → no output, and o_ready stays 1.
- i_ready held low for 10 cycles while in HI with byte 0x7C → o_data stays 0x37 and o_ready stays 0 throughout; 0x43 follows once i_ready rises.
- BYTES_PER_LINE = 1, bytes 0x00 and 0xFF → 0x30, 0x30, CR, LF, 0x46, 0x46, CR, LF, with no separator.
- i_rst pulsed while in LO → next cycle o_valid = 0 and o_ready = 1; the next byte 0x12 emits 0x31, 0x32, then a separator with r_count = 1.

Source files
------------

// File: rtl/uart_hex_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_hex_pkg
// Desc   : State encoding and ASCII constants shared by the hex framer.
//          The terminator form is selected by UART_HEX_FRAMER_CRLF_EN.
// Rev    : 1.0
// ============================================================================
package uart_hex_pkg;

`ifdef UART_HEX_FRAMER_CRLF_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_SEP  = 3'd3,
    ST_CR   = 3'd4,
    ST_LF   = 3'd5
  } state_t;
  localparam state_t c_ST_TERM = ST_CR;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_SEP  = 3'd3,
    ST_LF   = 3'd5
  } state_t;
  localparam state_t c_ST_TERM = ST_LF;
`endif

  localparam logic [7:0] c_ASCII_CR    = 8'h0D;
  localparam logic [7:0] c_ASCII_LF    = 8'h0A;
  localparam logic [7:0] c_ASCII_ZERO  = 8'h30;
  localparam logic [7:0] c_ASCII_A_M10 = 8'h37;

endpackage
`default_nettype wire

// File: rtl/nibble_to_ascii.sv
`default_nettype none
// ============================================================================
// Module : nibble_to_ascii
// Desc   : Combinational 4-bit value to uppercase ASCII hex character.
// Rev    : 1.0
// ============================================================================
module nibble_to_ascii (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_char
);
  import uart_hex_pkg::*;

  always_comb begin
    if (i_nibble <= 4'd9) begin
      o_char = c_ASCII_ZERO + {4'h0, i_nibble};
    end else begin
      o_char = c_ASCII_A_M10 + {4'h0, i_nibble};
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_hex_framer.sv
`default_nettype none
// ============================================================================
// Module : uart_hex_framer
// Desc   : Byte stream to ASCII hex text with separators and line terminators.
//          Define UART_HEX_FRAMER_CRLF_EN for CR+LF, otherwise LF only.
// Rev    : 1.0
// ============================================================================
module uart_hex_framer #(
  parameter int         DATA_DEPTH     = 8,
  parameter int         BYTES_PER_LINE = 2,
  parameter logic [7:0] SEP_CHAR       = 8'd32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_DEPTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [7:0]            o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  input  logic                  i_flush,
  output logic                  o_busy
);
  import uart_hex_pkg::*;

  localparam int              c_CW   = $clog2(BYTES_PER_LINE + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(BYTES_PER_LINE);

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_DEPTH-1:0] r_byte;
  logic [c_CW-1:0]       r_count;
  logic [c_CW-1:0]       w_count_inc;
  logic                  w_flush_take;
  logic                  w_in_hs;
  logic                  w_out_hs;
  logic                  w_line_end;
  logic [3:0]            w_nibble;
  logic [7:0]            w_hex;

  assign w_nibble = (r_state == ST_HI) ? r_byte[DATA_DEPTH-1:DATA_DEPTH-4] : r_byte[3:0];

  nibble_to_ascii u_nibble_to_ascii (
    .i_nibble (w_nibble),
    .o_char   (w_hex)
  );

  always_comb begin
    w_state_next = r_state;
    o_data       = '0;
    // A flush only counts when there is a partial line to close, and it beats i_valid.
    w_flush_take = (r_state == ST_IDLE) && i_flush && (r_count != '0);
    o_ready      = (r_state == ST_IDLE) && !w_flush_take;
    o_valid      = (r_state != ST_IDLE);
    o_busy       = o_valid;
    w_in_hs      = i_valid && o_ready;
    w_out_hs     = o_valid && i_ready;
    w_count_inc  = r_count + 1'b1;
    w_line_end   = (w_count_inc == c_LAST);

    unique case (r_state)
      ST_IDLE: begin
        if (w_flush_take) begin
          w_state_next = c_ST_TERM;
        end else if (w_in_hs) begin
          w_state_next = ST_HI;
        end
      end
      ST_HI: begin
        o_data = w_hex;
        if (w_out_hs) w_state_next = ST_LO;
      end
      ST_LO: begin
        o_data = w_hex;
        if (w_out_hs) w_state_next = w_line_end ? c_ST_TERM : ST_SEP;
      end
      ST_SEP: begin
        o_data = SEP_CHAR;
        if (w_out_hs) w_state_next = ST_IDLE;
      end
`ifdef UART_HEX_FRAMER_CRLF_EN
      ST_CR: begin
        o_data = c_ASCII_CR;
        if (w_out_hs) w_state_next = ST_LF;
      end
`endif
      ST_LF: begin
        o_data = c_ASCII_LF;
        if (w_out_hs) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_byte  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_in_hs) begin
        r_byte <= i_data;
      end
      if ((r_state == ST_LO) && w_out_hs) begin
        r_count <= w_line_end ? '0 : w_count_inc;
      end else if ((r_state == ST_LF) && w_out_hs) begin
        r_count <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_framer.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_hex_framer
// Desc   : Self-checking bench: character-stream model plus literal sequences,
//          two instances (2 and 1 bytes per line). Honours UART_HEX_FRAMER_CRLF_EN.
// Rev    : 1.0
// ============================================================================
module tb_uart_hex_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din  [2];
  logic       vin  [2];
  logic       rdy  [2];
  logic [7:0] dout [2];
  logic       vout [2];
  logic       ird  [2];
  logic       fl   [2];
  logic       busy [2];

  always #5 clk = ~clk;

  uart_hex_framer #(.BYTES_PER_LINE(2)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_data(din[0]), .i_valid(vin[0]), .o_ready(rdy[0]),
    .o_data(dout[0]), .o_valid(vout[0]), .i_ready(ird[0]), .i_flush(fl[0]), .o_busy(busy[0])
  );

  uart_hex_framer #(.BYTES_PER_LINE(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_data(din[1]), .i_valid(vin[1]), .o_ready(rdy[1]),
    .o_data(dout[1]), .o_valid(vout[1]), .i_ready(ird[1]), .i_flush(fl[1]), .o_busy(busy[1])
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] expb [2][128];
  int         wp [2];
  int         rp [2];
  int         mcount [2];
  int         bpl [2];
  logic [7:0] logb [2][128];
  int         logn [2];
  logic       hs_in [2];
  logic [63:0] lv;
  int          ln;
  int          s;

  task automatic check8(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, k, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input int n);
    if (n < 10) return 8'(48 + n);
    return 8'(65 + n - 10);
  endfunction

  task automatic push(input int k, input logic [7:0] c);
    expb[k][wp[k] % 128] = c;
    wp[k]++;
  endtask

  task automatic push_term(input int k);
`ifdef UART_HEX_FRAMER_CRLF_EN
    push(k, 8'h0D);
`endif
    push(k, 8'h0A);
  endtask

  // Each accepted byte yields two hex chars then either a separator or the line terminator.
  task automatic push_byte(input int k, input logic [7:0] b);
    push(k, hexc(int'(b[7:4])));
    push(k, hexc(int'(b[3:0])));
    mcount[k]++;
    if (mcount[k] == bpl[k]) begin
      push_term(k);
      mcount[k] = 0;
    end else begin
      push(k, 8'h20);
    end
  endtask

  task automatic monitor(input int k);
    int n;
    n = wp[k] - rp[k];
    hs_in[k] = 1'b0;
    if (rst) begin
      wp[k] = 0; rp[k] = 0; mcount[k] = 0;
    end else begin
      check8("busy", k, {7'b0, busy[k]}, {7'b0, n != 0});
      check8("valid", k, {7'b0, vout[k]}, {7'b0, n != 0});
      check8("ready", k, {7'b0, rdy[k]}, {7'b0, (n == 0) && !(fl[k] && mcount[k] != 0)});
      if (n != 0) check8("data", k, dout[k], expb[k][rp[k] % 128]);
      if (vout[k] && ird[k] && n != 0) begin
        logb[k][logn[k] % 128] = dout[k];
        logn[k]++;
        rp[k]++;
      end
      if (vin[k] && rdy[k]) begin
        hs_in[k] = 1'b1;
        push_byte(k, din[k]);
      end
      if (fl[k] && n == 0 && mcount[k] != 0) begin
        push_term(k);
        mcount[k] = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor(0);
    monitor(1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] b);
    int t;
    t = 0;
    din[k] = b;
    vin[k] = 1'b1;
    do begin
      tick();
      t++;
    end while (!hs_in[k] && t < 100);
    vin[k] = 1'b0;
    check8("send_accept", k, {7'b0, hs_in[k]}, 8'h01);
  endtask

  task automatic drain(input int k);
    int t;
    t = 0;
    while (((wp[k] - rp[k]) != 0 || busy[k]) && t < 200) begin
      tick();
      t++;
    end
    check8("drain_done", k, {7'b0, t < 200}, 8'h01);
  endtask

  task automatic lit_clr();
    lv = '0;
    ln = 0;
  endtask

  task automatic lit_add(input logic [7:0] c);
    lv[63 - 8*ln -: 8] = c;
    ln++;
  endtask

  task automatic lit_term();
`ifdef UART_HEX_FRAMER_CRLF_EN
    lit_add(8'h0D);
`endif
    lit_add(8'h0A);
  endtask

  task automatic check_seq(input string nm, input int k, input int start);
    check8({nm, "_len"}, k, 8'(logn[k] - start), 8'(ln));
    for (int i = 0; i < ln; i++) begin
      check8(nm, k, logb[k][(start + i) % 128], lv[63 - 8*i -: 8]);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      din[k] = '0; vin[k] = 1'b0; ird[k] = 1'b1; fl[k] = 1'b0;
      wp[k] = 0; rp[k] = 0; mcount[k] = 0; logn[k] = 0; hs_in[k] = 1'b0;
    end
    bpl[0] = 2;
    bpl[1] = 1;
    #2 rst = 1'b1;
    repeat (3) tick();
    check8("rst_valid", 0, {7'b0, vout[0]}, 8'h00);
    check8("rst_ready", 0, {7'b0, rdy[0]}, 8'h01);
    check8("rst_data", 0, dout[0], 8'h00);
    check8("rst_busy", 0, {7'b0, busy[0]}, 8'h00);
    rst = 1'b0;
    tick();

    // Two bytes make one full line.
    s = logn[0];
    send(0, 8'h3A);
    send(0, 8'hF0);
    drain(0);
    lit_clr();
    lit_add(8'h33); lit_add(8'h41); lit_add(8'h20); lit_add(8'h46); lit_add(8'h30); lit_term();
    check_seq("line_3A_F0", 0, s);
    check8("idle_after_line", 0, {7'b0, busy[0]}, 8'h00);

    // Flush on an empty line does nothing.
    s = logn[0];
    fl[0] = 1'b1;
    #1 check8("flush_empty_ready", 0, {7'b0, rdy[0]}, 8'h01);
    tick();
    fl[0] = 1'b0;
    repeat (3) tick();
    check8("flush_empty_out", 0, 8'(logn[0] - s), 8'h00);

    // Flush closes a partial line after its separator.
    s = logn[0];
    send(0, 8'h09);
    drain(0);
    fl[0] = 1'b1;
    #1 check8("flush_part_ready", 0, {7'b0, rdy[0]}, 8'h00);
    tick();
    fl[0] = 1'b0;
    drain(0);
    lit_clr();
    lit_add(8'h30); lit_add(8'h39); lit_add(8'h20); lit_term();
    check_seq("flush_09", 0, s);

    // Backpressure holds the high-nibble character.
    s = logn[0];
    ird[0] = 1'b0;
    send(0, 8'h7C);
    repeat (10) tick();
    check8("bp_data", 0, dout[0], 8'h37);
    check8("bp_ready", 0, {7'b0, rdy[0]}, 8'h00);
    ird[0] = 1'b1;
    drain(0);
    lit_clr();
    lit_add(8'h37); lit_add(8'h43); lit_add(8'h20);
    check_seq("bp_7C", 0, s);
    send(0, 8'h00);
    drain(0);

    // Reset while in LO abandons the line.
    send(0, 8'h55);
    tick();
    check8("pre_rst_lo", 0, dout[0], 8'h35);
    rst = 1'b1;
    #1;
    check8("mid_rst_valid", 0, {7'b0, vout[0]}, 8'h00);
    check8("mid_rst_ready", 0, {7'b0, rdy[0]}, 8'h01);
    tick();
    rst = 1'b0;
    tick();
    s = logn[0];
    send(0, 8'h12);
    drain(0);
    send(0, 8'h45);
    drain(0);
    lit_clr();
    lit_add(8'h31); lit_add(8'h32); lit_add(8'h20); lit_add(8'h34); lit_add(8'h35); lit_term();
    check_seq("after_rst", 0, s);

    // One byte per line: never a separator.
    s = logn[1];
    send(1, 8'h00);
    send(1, 8'hFF);
    drain(1);
    lit_clr();
    lit_add(8'h30); lit_add(8'h30); lit_term(); lit_add(8'h46); lit_add(8'h46); lit_term();
    check_seq("bpl1", 1, s);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
